// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scanner: DIGITS positions, per-digit dp/enable/blink, 8-level PWM, guard gap.
// Latency: one cycle from cnt/ptr/blink state and inputs to the registered seg_n/an_n pins.
// Backpressure: none; free-running scan, inputs sampled every cycle.
// Optional macro SEVEN_SEGMENT_SCAN_HEX_EN: decode nibbles 10..15 as A,b,C,d,E,F (otherwise blank).
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   digit_data[4*DIGITS]  : packed nibbles, digit 0 rightmost at [3:0]
//   dp_in, digit_en, blink_mask [DIGITS] : per-digit dp request, enable, blink mask
//   brightness[3]         : 0 dimmest .. 7 full
//   seg_n[8]              : active-low segments, [7]=dp, [6:0]=g..a
//   an_n[DIGITS]          : active-low anodes, at most one low
module seven_segment_scan #(
  parameter int DIGITS         = 8,
  parameter int REFRESH_CYCLES = 100_000,
  parameter int GUARD_CYCLES   = 1_000,
  parameter int BLINK_CYCLES   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [2:0]            brightness,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  // Room for (brightness+1)*REFRESH_CYCLES, up to 8*REFRESH_CYCLES, without truncation.
  localparam int LW = CW + 4;
  // Per-digit vectors are padded to a power of two so ptr indexes them without range issues.
  localparam int NP = 1 << PW;

  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_CYCLES - 1);
  localparam logic [PW-1:0] PTR_MAX   = PW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);
  localparam logic [LW-1:0] GUARD     = LW'(GUARD_CYCLES);
  localparam logic [LW-1:0] REFRESH   = LW'(REFRESH_CYCLES);

  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Scan and blink timebases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      ptr         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        ptr <= (ptr == PTR_MAX) ? '0 : ptr + PW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  logic [4*NP-1:0] data_pad;
  logic [NP-1:0]   dp_pad;
  logic [NP-1:0]   en_pad;
  logic [NP-1:0]   bm_pad;
  logic [3:0]      nibble;
  logic [LW-1:0]   limit;
  logic [LW-1:0]   cnt_ext;
  logic            in_window;
  logic            lit;
  logic [6:0]      seg_dec;
  logic [DIGITS-1:0] an_onehot;

  assign data_pad = (4*NP)'(digit_data);
  assign dp_pad   = NP'(dp_in);
  assign en_pad   = NP'(digit_en);
  assign bm_pad   = NP'(blink_mask);
  assign nibble   = data_pad[{ptr, 2'b00} +: 4];

  always_comb begin
    limit     = ((LW'(brightness) + LW'(1)) * REFRESH) >> 3;
    cnt_ext   = LW'(cnt);
    // Guard gap at slot start keeps the previous anode off before the next one turns on.
    in_window = (cnt_ext >= GUARD) && (cnt_ext < limit);
    lit       = in_window && en_pad[ptr] && !(bm_pad[ptr] && blink_phase);
    an_onehot = DIGITS'(1) << ptr;
  end

  always_comb begin
    seg_dec = 7'h7F;
    case (nibble)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
`ifdef SEVEN_SEGMENT_SCAN_HEX_EN
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
`else
      default: seg_dec = 7'h7F;
`endif
    endcase
  end

  // Pins are registered so the anode/segment edges are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= '1;
      seg_n <= 8'hFF;
    end else if (lit) begin
      an_n  <= ~an_onehot;
      seg_n <= {~dp_pad[ptr], seg_dec};
    end else begin
      an_n  <= '1;
      seg_n <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
module tb_seven_segment_scan;

  localparam int D  = 4;
  localparam int RC = 16;
  localparam int GC = 2;
  localparam int BC = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digit_data = 16'h1234;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  blink_mask = 4'h0;
  logic [2:0]  brightness = 3'd7;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;

  int n_assert = 0;
  int n_fail   = 0;
  int e        = 0;   // rising edges since reset release

  seven_segment_scan #(
    .DIGITS(D), .REFRESH_CYCLES(RC), .GUARD_CYCLES(GC), .BLINK_CYCLES(BC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digit_data(digit_data), .dp_in(dp_in),
    .digit_en(digit_en), .blink_mask(blink_mask), .brightness(brightness),
    .seg_n(seg_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
`ifdef SEVEN_SEGMENT_SCAN_HEX_EN
          7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
          7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
    return t[v];
  endfunction

  // Pins after edge number k+1 (counting from release) reflect the timeline at cycle k.
  task automatic model(input int k, output logic [3:0] x_an, output logic [7:0] x_seg);
    int cnt, p, bp, lim;
    logic lit;
    cnt = k % RC;
    p   = (k / RC) % D;
    bp  = (k / BC) % 2;
    lim = ((int'(brightness) + 1) * RC) / 8;
    lit = (cnt >= GC) && (cnt < lim) && digit_en[p] && !(blink_mask[p] && bp == 1);
    if (lit) begin
      x_an  = 4'hF & ~(4'h1 << p);
      x_seg = {~dp_in[p], decode(digit_data[4*p +: 4])};
    end else begin
      x_an  = 4'hF;
      x_seg = 8'hFF;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, obs, exp_v);
    end
  endtask

  task automatic step_check(input string tag);
    logic [3:0] x_an;
    logic [7:0] x_seg;
    @(posedge clk);
    #1;
    e++;
    model(e - 1, x_an, x_seg);
    chk({tag, "_an"}, {4'h0, an_n}, {4'h0, x_an});
    chk({tag, "_seg"}, seg_n, x_seg);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step_check(tag);
  endtask

  initial begin
    // Reset held: pins dark.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("reset_an", {4'h0, an_n}, 8'h0F);
      chk("reset_seg", seg_n, 8'hFF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;

    // Full brightness scan of 1234.
    run("scan", 64);
    brightness = 3'd0;
    run("bright0", 64);
    brightness = 3'd3;
    run("bright3", 64);
    brightness = 3'd7;
    blink_mask = 4'b0010;
    digit_en   = 4'b1011;
    run("blink_en", 256);
    blink_mask = 4'h0;
    digit_en   = 4'hF;
    dp_in      = 4'b0100;
    digit_data = 16'h0800;
    run("dp", 64);
    dp_in      = 4'h0;
    digit_data = 16'hABCF;
    run("hex", 64);
    digit_data = 16'h5678;

    // Randomized inputs, occasionally changing between edges.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: digit_data = 16'($urandom);
          1: dp_in      = 4'($urandom);
          2: digit_en   = 4'($urandom);
          3: blink_mask = 4'($urandom);
          default: brightness = 3'($urandom);
        endcase
      end
      step_check("rand");
    end

    // Mid-slot reset: advance until the timeline sits at cnt=9 of slot 2.
    digit_data = 16'h1234; dp_in = 4'h0; digit_en = 4'hF; blink_mask = 4'h0; brightness = 3'd7;
    for (int i = 0; i < 64 && (e % 64) != (2 * RC + 9); i++) step_check("pre_rst");
    chk("pre_rst_lit_an", {4'h0, an_n}, 8'h0B);
    rst_n = 1'b0;
    #1;
    chk("midrst_an", {4'h0, an_n}, 8'h0F);
    chk("midrst_seg", seg_n, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_hold_an", {4'h0, an_n}, 8'h0F);
      chk("midrst_hold_seg", seg_n, 8'hFF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    run("post_rst", 3);
    chk("post_rst_first_lit", {4'h0, an_n}, 8'h0E);
    run("post_rst", 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
